uart_32_bit_rx_word: RTL

- UART receive path for the 32-bit UART: samples the serial `rx` line on an oversampling tick and validates start and stop bits.
- Assembles four consecutive 8N1 frames into one 32-bit word, least-significant byte first.
- Presents the word to the register interface with a valid/ack handshake and reports framing and overrun errors.
- It is the receive-side counterpart to the 32-bit transmitter; `baud_tick` comes from the existing baud-rate generator.

---
 rtl/uart_32_bit_rx_word.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_32_bit_rx_word.sv
// UART receiver: oversampled 8N1 frames assembled LSB-byte-first into a 32-bit word,
// presented with a valid/ack handshake plus sticky framing and overrun flags.
module uart_32_bit_rx_word #(
    parameter int OVERSAMPLE     = 16,
    parameter int DATA_BITS      = 8,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                baud_tick,
    input  logic                                rx,
    input  logic                                data_ack,
    input  logic                                err_clear,
    output logic [DATA_BITS*BYTES_PER_WORD-1:0] data,
    output logic                                data_valid,
    output logic                                frame_error,
    output logic                                overrun,
    output logic                                busy
);
    localparam int WORD_W = DATA_BITS * BYTES_PER_WORD;
    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [WORD_W-1:0]      data_q, data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   frame_error_q, frame_error_d;
    logic                   overrun_q, overrun_d;
    logic                   word_done, stop_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            byte_idx_q    <= '0;
            shreg_q       <= '0;
            word_q        <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rx_s_q        <= rx_meta_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            byte_idx_q    <= byte_idx_d;
            shreg_q       <= shreg_d;
            word_q        <= word_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        byte_idx_d    = byte_idx_q;
        shreg_d       = shreg_q;
        word_d        = word_q;
        data_d        = data_q;
        data_valid_d  = data_valid_q;
        frame_error_d = frame_error_q;
        overrun_d     = overrun_q;
        word_done     = 1'b0;
        stop_bad      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: if (baud_tick) begin
                // Mid-start-bit recheck rejects glitches shorter than half a bit.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: if (baud_tick) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    if (bit_idx_q == BIT_MAX) begin
                        bit_idx_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: if (baud_tick) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        word_d[int'(byte_idx_q)*DATA_BITS +: DATA_BITS] = shreg_q;
                        if (byte_idx_q == IDX_MAX) begin
                            byte_idx_d = '0;
                            word_done  = 1'b1;
                        end else begin
                            byte_idx_d = byte_idx_q + IDX_W'(1);
                        end
                        state_d = S_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        byte_idx_d = '0;
                        state_d    = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (err_clear) begin
            frame_error_d = 1'b0;
            overrun_d     = 1'b0;
        end
        // Set events are applied after the clear so they win on a collision.
        if (stop_bad) frame_error_d = 1'b1;
        if (word_done) begin
            if (!data_valid_q || data_ack) begin
                data_d       = word_d;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_ack) begin
            data_valid_d = 1'b0;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != S_IDLE);

endmodule
